// File: rtl/phase_arbiter.sv
// Round-robin arbiter granting one of four requesters ownership of the shared
// four-phase sequencer, with a bounded hold time and a dead cycle between owners.
module phase_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             win_found;
  logic [1:0]       win_idx;

  // Rotating-priority search; scanning offsets high-to-low lets the nearest one win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(ptr_q + 2'(k))]) begin
        win_found = 1'b1;
        win_idx   = 2'(ptr_q + 2'(k));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (win_found) begin
          state_d = S_GRANT;
          grant_d = 4'(4'b0001 << win_idx);
          owner_d = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end

      S_GRANT: begin
        if (!req[owner_q] || (hold_q == HOLD_LAST)) begin
          // Owner index is kept so downstream phase select stays stable.
          state_d   = S_RELEASE;
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = 2'(owner_q + 2'd1);
          hold_d    = '0;
          timeout_d = req[owner_q];
        end else begin
          hold_d = CNT_W'(hold_q + CNT_W'(1));
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 2'd0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
